// File: rtl/bsearch_ctrl.sv
// Binary-search sequencing controller: steps an external LOW/HIGH/MID datapath over a sorted RAM.
// Optional macro BSEARCH_PIPE_READ_EN stretches WAIT to two cycles for a registered-output RAM.
//
// state | meaning
// IDLE  | waiting for start; result held
// INIT  | dp_rst pulse, shadow bounds reset
// WAIT  | RAM read latency (1 or 2 cycles)
// CMP   | compare currA with target, decide hit / empty / step
// STEP  | one lookUp or lookDown pulse
// DONE  | one-cycle done pulse
module bsearch_ctrl #(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] A,
    input  logic [DW-1:0] currA,
    input  logic [AW-1:0] A_addr,
    output logic          dp_rst,
    output logic          lookUp,
    output logic          lookDown,
    output logic          busy,
    output logic          done,
    output logic          found,
    output logic [AW-1:0] loc
);

`ifdef BSEARCH_PIPE_READ_EN
    localparam int WAIT_CYC = 2;
`else
    localparam int WAIT_CYC = 1;
`endif
    localparam logic [0:0]  WAIT_LD = 1'(WAIT_CYC - 1);
    localparam logic [AW:0] HI_MAX  = {1'b0, {AW{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_WAIT, S_CMP, S_STEP, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] tgt_q, tgt_d;
    logic [AW:0]   lo_q, lo_d, hi_q, hi_d;
    logic          up_q, up_d;
    logic [0:0]    wait_q, wait_d;
    logic          found_q, found_d;
    logic [AW-1:0] loc_q, loc_d;

    logic [AW:0]   lo_n, hi_n;
    logic          empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tgt_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            up_q    <= 1'b0;
            wait_q  <= '0;
            found_q <= 1'b0;
            loc_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            up_q    <= up_d;
            wait_q  <= wait_d;
            found_q <= found_d;
            loc_q   <= loc_d;
        end
    end

    // Guard bit: A_addr-1 at 0 underflows into bit AW, A_addr+1 at max lands above any hi.
    always_comb begin
        lo_n = lo_q;
        hi_n = hi_q;
        if (currA < tgt_q)
            lo_n = {1'b0, A_addr} + {{AW{1'b0}}, 1'b1};
        else if (currA > tgt_q)
            hi_n = {1'b0, A_addr} - {{AW{1'b0}}, 1'b1};
        empty = hi_n[AW] | (lo_n > hi_n);
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        up_d    = up_q;
        wait_d  = wait_q;
        found_d = found_q;
        loc_d   = loc_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tgt_d   = A;
                    found_d = 1'b0;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                lo_d    = '0;
                hi_d    = HI_MAX;
                wait_d  = WAIT_LD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == '0)
                    state_d = S_CMP;
                else
                    wait_d = wait_q - 1'b1;
            end
            S_CMP: begin
                if (currA == tgt_q) begin
                    found_d = 1'b1;
                    loc_d   = A_addr;
                    state_d = S_DONE;
                end else if (empty) begin
                    found_d = 1'b0;
                    state_d = S_DONE;
                end else begin
                    up_d    = (currA < tgt_q);
                    lo_d    = lo_n;
                    hi_d    = hi_n;
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                wait_d  = WAIT_LD;
                state_d = S_WAIT;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pulses are masked by rst so a reset mid-search issues no step or done.
    assign dp_rst   = rst | (state_q == S_INIT);
    assign lookUp   = ~rst & (state_q == S_STEP) & up_q;
    assign lookDown = ~rst & (state_q == S_STEP) & ~up_q;
    assign done     = ~rst & (state_q == S_DONE);
    assign busy     = (state_q != S_IDLE);
    assign found    = found_q;
    assign loc      = loc_q;

endmodule

// File: tb/tb_bsearch_ctrl.sv
// Bench for bsearch_ctrl: behavioural datapath + RAM (RAM[i]=8*i), table vectors,
// hand sequences for ignored start / mid-search reset, and random targets against a reference search.
module tb_bsearch_ctrl;

`ifdef BSEARCH_PIPE_READ_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, start;
    logic [7:0] A, currA;
    logic [4:0] A_addr, loc;
    logic       dp_rst, lookUp, lookDown, busy, done, found;

    logic [7:0] mem [32];
    logic [4:0] dp_low, dp_high;
    logic [5:0] dp_sum;
    logic [7:0] rd1, rd2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bsearch_ctrl #(.DW(8), .AW(5)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .currA(currA), .A_addr(A_addr),
        .dp_rst(dp_rst), .lookUp(lookUp), .lookDown(lookDown), .busy(busy),
        .done(done), .found(found), .loc(loc)
    );

    // Datapath: MID = (LOW+HIGH)/2, synchronous RAM read (extra register stage in pipe mode).
    assign dp_sum = 6'(dp_low) + 6'(dp_high);
    assign A_addr = dp_sum[5:1];
    assign currA  = PIPE ? rd2 : rd1;

    always @(posedge clk) begin
        if (dp_rst) begin
            dp_low  <= 5'd0;
            dp_high <= 5'd31;
        end else if (lookUp) begin
            dp_low <= A_addr + 5'd1;
        end else if (lookDown) begin
            dp_high <= A_addr - 5'd1;
        end
        rd1 <= mem[A_addr];
        rd2 <= rd1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int lat_of(input int p);
        return PIPE ? 5 + 4 * (p - 1) : 4 + 3 * (p - 1);
    endfunction

    // Reference: plain textbook binary search over the array.
    function automatic void ref_search(input int t, output int f, output int lc,
                                       output int p, output int ups, output int downs);
        int lo = 0;
        int hi = 31;
        int mid;
        f = 0; lc = 0; p = 0; ups = 0; downs = 0;
        while (lo <= hi) begin
            mid = (lo + hi) / 2;
            p++;
            if (int'(mem[mid]) == t) begin
                f = 1;
                lc = mid;
                return;
            end
            if (int'(mem[mid]) < t) begin
                lo = mid + 1;
                if (lo <= hi) ups++;
            end else begin
                hi = mid - 1;
                if (lo <= hi) downs++;
            end
        end
    endfunction

    // Runs one search. cyc counts cycles after the edge that sampled start (INIT is cyc 1).
    task automatic run_search(input logic [7:0] a, input int inj_start, input int inj_rst,
                              output int seen_done, output int lat, output int f, output int lc,
                              output int ups, output int downs, output int viol, output int post_rst);
        int cyc;
        seen_done = 0; lat = 0; f = 0; lc = 0; ups = 0; downs = 0; viol = 0; post_rst = 0;
        @(negedge clk);
        start = 1'b1;
        A     = a;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        chk("busy_after_start", int'(busy), 1);
        chk("dp_rst_in_init", int'(dp_rst), 1);
        while (cyc <= 40) begin
            if (lookUp) ups++;
            if (lookDown) downs++;
            if ((lookUp && lookDown) || (lookUp && A_addr == 5'd31) || (lookDown && A_addr == 5'd0))
                viol++;
            if (inj_rst > 0 && cyc > inj_rst && (lookUp || lookDown)) post_rst++;
            if (done) begin
                seen_done = 1;
                lat = cyc;
                f   = int'(found);
                lc  = int'(loc);
                break;
            end
            if (cyc == inj_start) begin
                start = 1'b1;
                A     = 8'd120;
            end else if (inj_start > 0 && cyc == inj_start + 1) begin
                start = 1'b0;
            end
            if (cyc == inj_rst) rst = 1'b1;
            if (inj_rst > 0 && cyc == inj_rst + 1) begin
                chk("rst_busy_cleared", int'(busy), 0);
                chk("rst_dp_rst", int'(dp_rst), 1);
                rst = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (seen_done) begin
            @(posedge clk);
            #1;
            chk("idle_after_done", int'(busy), 0);
            chk("found_held", int'(found), f);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        int         fnd;
        int         lc;
        int         p;
        int         ups;
        int         downs;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int sd, lat, f, lc, ups, downs, viol, pr;
        int ef, elc, ep, eups, edowns;
        logic [7:0] t;

        tbl[0] = '{8'd120, 1, 15, 1, 0, 0};
        tbl[1] = '{8'd0,   1, 0,  5, 0, 4};
        tbl[2] = '{8'd248, 1, 31, 6, 5, 0};
        tbl[3] = '{8'd5,   0, 0,  5, 0, 4};
        tbl[4] = '{8'd255, 0, 0,  6, 5, 0};
        tbl[5] = '{8'd8,   1, 1,  4, 0, 3};
        tbl[6] = '{8'd128, 1, 16, 5, 1, 3};

        for (int i = 0; i < 32; i++) mem[i] = 8'(8 * i);

        rst = 1'b1; start = 1'b0; A = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_found", int'(found), 0);
        chk("rst_loc", int'(loc), 0);
        chk("rst_lookUp", int'(lookUp), 0);
        chk("rst_lookDown", int'(lookDown), 0);
        chk("rst_dp_rst", int'(dp_rst), 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_dp_rst", int'(dp_rst), 0);

        for (int i = 0; i < 7; i++) begin
            run_search(tbl[i].a, 0, 0, sd, lat, f, lc, ups, downs, viol, pr);
            chk("tbl_done_seen", sd, 1);
            chk("tbl_latency", lat, lat_of(tbl[i].p));
            chk("tbl_found", f, tbl[i].fnd);
            if (tbl[i].fnd == 1) chk("tbl_loc", lc, tbl[i].lc);
            chk("tbl_lookUp_count", ups, tbl[i].ups);
            chk("tbl_lookDown_count", downs, tbl[i].downs);
            chk("tbl_protocol", viol, 0);
        end

        // start during busy must not reload the target
        run_search(8'd0, 6, 0, sd, lat, f, lc, ups, downs, viol, pr);
        chk("ign_done_seen", sd, 1);
        chk("ign_found", f, 1);
        chk("ign_loc", lc, 0);
        chk("ign_latency", lat, lat_of(5));

        // reset mid-search: no done, no further pulses, result cleared
        run_search(8'd0, 0, 8, sd, lat, f, lc, ups, downs, viol, pr);
        chk("rst_mid_no_done", sd, 0);
        chk("rst_mid_no_pulses", pr, 0);
        chk("rst_mid_found", int'(found), 0);
        chk("rst_mid_loc", int'(loc), 0);
        chk("rst_mid_idle", int'(busy), 0);
        run_search(8'd8, 0, 0, sd, lat, f, lc, ups, downs, viol, pr);
        chk("post_rst_done_seen", sd, 1);
        chk("post_rst_found", f, 1);
        chk("post_rst_loc", lc, 1);

        for (int n = 0; n < 40; n++) begin
            t = 8'($urandom_range(0, 255));
            ref_search(int'(t), ef, elc, ep, eups, edowns);
            run_search(t, 0, 0, sd, lat, f, lc, ups, downs, viol, pr);
            chk("rnd_done_seen", sd, 1);
            chk("rnd_latency", lat, lat_of(ep));
            chk("rnd_found", f, ef);
            if (ef == 1) chk("rnd_loc", lc, elc);
            chk("rnd_lookUp_count", ups, eups);
            chk("rnd_lookDown_count", downs, edowns);
            chk("rnd_protocol", viol, 0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
